// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer raising irq to CP0.
// Optional macro TC_INT_ACK_EN adds the int_ack port as an extra PEND clear.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
`ifdef TC_INT_ACK_EN
  ,
  input  logic        int_ack
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      state;
  state_t      nxt;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic        pend;
  logic [31:0] preset;
  logic [31:0] count;

  logic wr_ctrl;
  logic wr_preset;
  logic ack;
  logic pend_clr;
  logic expire;
  logic auto_rl;
  logic en_clr;

  assign wr_ctrl   = we && (addr == 2'd0);
  assign wr_preset = we && (addr == 2'd1);

`ifdef TC_INT_ACK_EN
  assign ack = int_ack;
`else
  assign ack = 1'b0;
`endif

  assign auto_rl  = (mode == 2'b01);
  assign pend_clr = (wr_ctrl && wdata[4]) || ack;
  assign expire   = (state == S_CNT) && en && (count <= 32'd1);
  assign en_clr   = (state == S_INT) && !auto_rl;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (en) nxt = S_LOAD;
      S_LOAD: nxt = S_CNT;
      S_CNT: begin
        if (!en)
          nxt = S_IDLE;
        else if (count <= 32'd1)
          nxt = S_INT;
      end
      S_INT: nxt = auto_rl ? S_LOAD : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      en     <= 1'b0;
      mode   <= 2'b00;
      im     <= 1'b0;
      pend   <= 1'b0;
      preset <= 32'd0;
      count  <= 32'd0;
    end else begin
      state <= nxt;
      // A CPU write in the INT cycle beats the one-shot EN clear
      if (wr_ctrl) begin
        en   <= wdata[0];
        mode <= wdata[2:1];
        im   <= wdata[3];
      end else if (en_clr) begin
        en <= 1'b0;
      end
      if (wr_preset)
        preset <= wdata;
      if (state == S_LOAD)
        count <= preset;
      else if (state == S_CNT && en)
        count <= (count > 32'd1) ? count - 32'd1 : 32'd0;
      // Expiry set wins over a same-cycle clear
      pend <= expire || (pend && !pend_clr);
    end
  end

  always_comb begin
    rdata = 32'd0;
    unique case (addr)
      2'd0: rdata = {27'd0, pend, im, mode, en};
      2'd1: rdata = preset;
      2'd2: rdata = count;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = pend && im;

endmodule
